// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants up to two of NREQ producers per cycle onto the registered CDB1/CDB2 broadcast buses
// Ports: clk_in/rst_in (sync, active-high)/rdy_in (freeze when low)/rob_clear (flush); req_valid/req_id/req_value
// in with combinational req_ready out; rob_head (age mode only); cdb1_*/cdb2_* rdy/id/value registered outputs.
// Optional macro CDB_AGE_PRIORITY_EN: oldest-first priority relative to rob_head instead of round-robin.
`ifndef RoB_BITS
`define RoB_BITS 4
`endif
module cdb_arbiter #(
  parameter int NREQ     = 4,
  parameter int ROB_BITS = `RoB_BITS,
  parameter int DATA_W   = 32
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     rob_clear,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ROB_BITS-1:0] req_id,
  input  logic [NREQ*DATA_W-1:0]   req_value,
  output logic [NREQ-1:0]          req_ready,
  input  logic [ROB_BITS-1:0]      rob_head,
  output logic                     cdb1_rdy,
  output logic [ROB_BITS-1:0]      cdb1_id,
  output logic [DATA_W-1:0]        cdb1_value,
  output logic                     cdb2_rdy,
  output logic [ROB_BITS-1:0]      cdb2_id,
  output logic [DATA_W-1:0]        cdb2_value
);
  localparam int PW = $clog2(NREQ);
  logic [PW-1:0] rr_ptr, ptr_nxt, g1, g2;
  logic has1, has2, active;
  logic [ROB_BITS-1:0] ids [NREQ];
  logic [DATA_W-1:0] vals [NREQ];
  genvar i;
  for (i = 0; i < NREQ; i++) begin : g_split
    assign ids[i]  = req_id[i*ROB_BITS +: ROB_BITS];
    assign vals[i] = req_value[i*DATA_W +: DATA_W];
  end
  assign active = rdy_in && !rst_in && !rob_clear;
  always_comb begin
    req_ready = '0;
    if (active && has1) req_ready[g1] = 1'b1;
    if (active && has2) req_ready[g2] = 1'b1;
  end
`ifdef CDB_AGE_PRIORITY_EN
  // key = distance from the RoB head; strict < keeps the lower index on ties
  logic [ROB_BITS-1:0] k1, k2, key;
  logic unused_ptr;
  assign unused_ptr = ^rr_ptr;
  assign ptr_nxt = '0;
  always_comb begin
    has1 = 1'b0;
    has2 = 1'b0;
    g1 = '0;
    g2 = '0;
    k1 = '0;
    k2 = '0;
    key = '0;
    for (int n = 0; n < NREQ; n++) begin
      key = ids[n] - rob_head;
      if (req_valid[n] && (!has1 || key < k1)) begin
        has1 = 1'b1;
        g1 = PW'(n);
        k1 = key;
      end
    end
    for (int n = 0; n < NREQ; n++) begin
      key = ids[n] - rob_head;
      if (req_valid[n] && PW'(n) != g1 && (!has2 || key < k2)) begin
        has2 = 1'b1;
        g2 = PW'(n);
        k2 = key;
      end
    end
  end
`else
  logic [PW-1:0] idx;
  logic unused_head;
  assign unused_head = ^rob_head;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] x);
    return (x == PW'(NREQ-1)) ? '0 : x + PW'(1);
  endfunction
  assign ptr_nxt = has2 ? inc(g2) : has1 ? inc(g1) : rr_ptr;
  always_comb begin
    has1 = 1'b0;
    has2 = 1'b0;
    g1 = '0;
    g2 = '0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k >= NREQ) ? PW'(int'(rr_ptr) + k - NREQ) : PW'(int'(rr_ptr) + k);
      if (req_valid[idx] && !has1) begin
        has1 = 1'b1;
        g1 = idx;
      end else if (req_valid[idx] && !has2) begin
        has2 = 1'b1;
        g2 = idx;
      end
    end
  end
`endif
  always_ff @(posedge clk_in) begin
    if (rst_in || rob_clear) begin
      rr_ptr     <= '0;
      cdb1_rdy   <= 1'b0;
      cdb1_id    <= '0;
      cdb1_value <= '0;
      cdb2_rdy   <= 1'b0;
      cdb2_id    <= '0;
      cdb2_value <= '0;
    end else if (rdy_in) begin
      rr_ptr   <= ptr_nxt;
      cdb1_rdy <= has1;
      cdb2_rdy <= has2;
      if (has1) begin
        cdb1_id    <= ids[g1];
        cdb1_value <= vals[g1];
      end
      if (has2) begin
        cdb2_id    <= ids[g2];
        cdb2_value <= vals[g2];
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: rank-based model of the CDB arbiter checked every cycle, plus directed literal checks
module tb_cdb_arbiter;
  localparam int N = 4, RB = 4, DW = 32;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, rob_clear;
  logic [N-1:0] req_valid, req_ready, exp_ready;
  logic [N*RB-1:0] req_id;
  logic [N*DW-1:0] req_value;
  logic [RB-1:0] rob_head;
  logic cdb1_rdy, cdb2_rdy;
  logic [RB-1:0] cdb1_id, cdb2_id;
  logic [DW-1:0] cdb1_value, cdb2_value;
  int total = 0, bad = 0;
  int m_ptr = 0, pa, pb;
  bit m1 = 0, m2 = 0;
  logic [RB-1:0] mid1, mid2;
  logic [DW-1:0] mv1, mv2;

  cdb_arbiter #(.NREQ(N), .ROB_BITS(RB), .DATA_W(DW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .req_valid(req_valid), .req_id(req_id), .req_value(req_value), .req_ready(req_ready),
    .rob_head(rob_head),
    .cdb1_rdy(cdb1_rdy), .cdb1_id(cdb1_id), .cdb1_value(cdb1_value),
    .cdb2_rdy(cdb2_rdy), .cdb2_id(cdb2_id), .cdb2_value(cdb2_value));

  always #5 clk_in = ~clk_in;

  // smaller rank = higher priority: circular distance from the pointer, or age relative to the head
  function automatic int rank(input int i, input int ptr, input logic [N*RB-1:0] ids, input logic [RB-1:0] head);
`ifdef CDB_AGE_PRIORITY_EN
    return ((int'(ids[i*RB +: RB]) - int'(head) + (1 << RB)) % (1 << RB)) * N + i;
`else
    return (i - ptr + N) % N;
`endif
  endfunction

  function automatic int best(input logic [N-1:0] v, input int ptr, input logic [N*RB-1:0] ids,
                              input logic [RB-1:0] head, input int excl);
    int b = -1;
    for (int i = 0; i < N; i++)
      if (v[i] && i != excl && (b < 0 || rank(i, ptr, ids, head) < rank(b, ptr, ids, head))) b = i;
    return b;
  endfunction

  always @* begin
    pa = best(req_valid, m_ptr, req_id, rob_head, -1);
    pb = (pa < 0) ? -1 : best(req_valid, m_ptr, req_id, rob_head, pa);
  end

  always @(posedge clk_in) begin
    if (rst_in || rob_clear) begin
      m1 <= 0;
      m2 <= 0;
      m_ptr <= 0;
    end else if (rdy_in) begin
      m1 <= pa >= 0;
      m2 <= pb >= 0;
      if (pa >= 0) begin
        mid1 <= req_id[pa*RB +: RB];
        mv1  <= req_value[pa*DW +: DW];
      end
      if (pb >= 0) begin
        mid2 <= req_id[pb*RB +: RB];
        mv2  <= req_value[pb*DW +: DW];
      end
      m_ptr <= (pb >= 0) ? (pb + 1) % N : (pa >= 0) ? (pa + 1) % N : m_ptr;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    exp_ready = '0;
    if (rdy_in && !rst_in && !rob_clear && pa >= 0) exp_ready[pa] = 1'b1;
    if (rdy_in && !rst_in && !rob_clear && pb >= 0) exp_ready[pb] = 1'b1;
    chk("m_ready", req_ready, exp_ready);
    chk("m_cdb1_rdy", cdb1_rdy, m1);
    chk("m_cdb2_rdy", cdb2_rdy, m2);
    if (m1) begin
      chk("m_cdb1_id", cdb1_id, mid1);
      chk("m_cdb1_value", cdb1_value, mv1);
    end
    if (m2) begin
      chk("m_cdb2_id", cdb2_id, mid2);
      chk("m_cdb2_value", cdb2_value, mv2);
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    rst_in = 1; rdy_in = 1; rob_clear = 0; req_valid = '1;
    req_id = '0; req_value = '0; rob_head = '0;
    tick(); tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_cdb1", cdb1_rdy, 0);
    chk("rst_cdb2", cdb2_rdy, 0);
    rst_in = 0; req_valid = 4'b0010; req_id = 16'h0050; req_value = {32'h0, 32'h0, 32'hDEAD, 32'h0};
    #1 chk("single_ready", req_ready, 4'b0010);
    tick();
    chk("single_cdb1_rdy", cdb1_rdy, 1);
    chk("single_cdb1_id", cdb1_id, 5);
    chk("single_cdb1_value", cdb1_value, 32'hDEAD);
    chk("single_cdb2_rdy", cdb2_rdy, 0);
    req_valid = 0;
`ifndef CDB_AGE_PRIORITY_EN
    rst_in = 1; tick(); rst_in = 0;
    req_valid = 4'b1111; req_id = 16'h4321; req_value = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    #1 chk("rr0_ready", req_ready, 4'b0011);
    tick();
    chk("rr0_id1", cdb1_id, 1);
    chk("rr0_id2", cdb2_id, 2);
    chk("rr1_ready", req_ready, 4'b1100);
    tick();
    chk("rr1_id1", cdb1_id, 3);
    chk("rr1_id2", cdb2_id, 4);
    chk("rr1_val2", cdb2_value, 32'hD3);
    chk("rr2_ready", req_ready, 4'b0011);
    tick();
    chk("rr2_id1", cdb1_id, 1);
    chk("rr2_id2", cdb2_id, 2);
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b1001;
    #1 chk("wrap_ready", req_ready, 4'b1001);
    tick();
    chk("wrap_id1", cdb1_id, 4);
    chk("wrap_id2", cdb2_id, 1);
    req_valid = 4'b1111;
    #1 chk("wrap_ptr1_ready", req_ready, 4'b0110);
    req_valid = 0;
`else
    req_valid = 4'b1111; rob_head = 14; req_id = 16'h10F2;
    #1 chk("age_ready", req_ready, 4'b0110);
    tick();
    chk("age_id1", cdb1_id, 15);
    chk("age_id2", cdb2_id, 0);
    req_valid = 0;
`endif
    req_valid = 4'b0010; req_id = 16'h0070; req_value = {32'h0, 32'h0, 32'hBEEF, 32'h0};
    tick();
    req_valid = 0; rdy_in = 0;
    #1 chk("stall_ready", req_ready, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_rdy", cdb1_rdy, 1);
      chk("stall_id", cdb1_id, 7);
      chk("stall_value", cdb1_value, 32'hBEEF);
    end
    rdy_in = 1;
    tick();
    chk("resume_rdy", cdb1_rdy, 0);
    req_valid = 4'b0011;
    tick();
    chk("preflush_rdy", cdb1_rdy, 1);
    rob_clear = 1; req_valid = 4'b1111;
    #1 chk("flush_ready", req_ready, 0);
    tick();
    chk("flush_cdb1", cdb1_rdy, 0);
    chk("flush_cdb2", cdb2_rdy, 0);
    rob_clear = 0;
    for (int k = 0; k < 80; k++) begin
      req_valid = N'($urandom);
      req_id = (N*RB)'($urandom);
      req_value = {$urandom, $urandom, $urandom, $urandom};
      rob_head = RB'($urandom);
      rdy_in = ($urandom % 4) != 0;
      rob_clear = ($urandom % 16) == 0;
      tick();
    end
    @(negedge clk_in);
    #1 $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
